// File: rtl/monitor_serializer_pkg.sv
// Shared types and helpers for the monitor verdict serializer.
package monitor_serializer_pkg;

  localparam int unsigned WORD_W          = 64;
  localparam int unsigned MAX_OUTPUTS     = 32;
  localparam int unsigned HDR_TS_MSB      = WORD_W - 1;
  localparam int unsigned HDR_MASK_LSB    = 0;

  localparam int unsigned DEF_NUM_OUTPUTS = 4;
  localparam int unsigned DEF_DATA_W      = 64;
  localparam int unsigned DEF_TS_W        = 32;

  typedef enum logic [1:0] {IDLE, HDR, VAL} ser_state_e;

  // Packed layout matches the flat FIFO word: {ts, mask, values[N-1..0]}
  typedef struct packed {
    logic [DEF_TS_W-1:0]                           ts;
    logic [DEF_NUM_OUTPUTS-1:0]                    mask;
    logic [DEF_NUM_OUTPUTS-1:0][DEF_DATA_W-1:0]    values;
  } record_t;

  // Lowest set index >= from, or MAX_OUTPUTS when none remains.
  function automatic logic [5:0] next_set_bit(input logic [MAX_OUTPUTS-1:0] mask,
                                              input logic [5:0]             from);
    logic [5:0] r;
    logic       found;
    r     = 6'(MAX_OUTPUTS);
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
      if (!found && mask[i] && (i >= 32'(from))) begin
        r     = 6'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/record_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens at the same edge.
module record_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     push_ok_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop_ok;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok_o = push_i && (!full_o || pop_i);
  assign pop_ok    = pop_i && !empty_o;
  assign rdata_o   = mem[rptr_q];
  assign level_o   = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok_o) wptr_d = wptr_q + AW'(1);
    if (pop_ok)    rptr_d = rptr_q + AW'(1);
    if (push_ok_o && !pop_ok)      level_d = level_q + (AW+1)'(1);
    else if (!push_ok_o && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/monitor_verdict_serializer.sv
// Captures active monitor cycles into records and streams each as a header plus value words.
module monitor_verdict_serializer
  import monitor_serializer_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TS_W        = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DROP_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] mon_data,
  input  logic [NUM_OUTPUTS-1:0]        mon_aktv,
  output logic [63:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned VALS_W = NUM_OUTPUTS * DATA_W;
  localparam int unsigned REC_W  = TS_W + NUM_OUTPUTS + VALS_W;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

  ser_state_e        state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [5:0]        idx_q, idx_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              push, pop, push_ok, full, empty;
  logic [REC_W-1:0]  wr_rec, rd_rec;

  assign push   = en && (|mon_aktv);
  assign wr_rec = {ts_q, mon_aktv, mon_data};

  record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (wr_rec),
    .rdata_o   (rd_rec),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level),
    .push_ok_o (push_ok)
  );

  logic [TS_W-1:0]        head_ts;
  logic [NUM_OUTPUTS-1:0] head_mask;
  logic [VALS_W-1:0]      head_vals;
  logic [MAX_OUTPUTS-1:0] mask_ext;
  logic [5:0]             first_idx, next_idx;
  logic                   is_last;
  logic [DATA_W-1:0]      cur_val;
  logic [63:0]            hdr_word, val_word;

  assign head_ts   = rd_rec[REC_W-1 -: TS_W];
  assign head_mask = rd_rec[VALS_W +: NUM_OUTPUTS];
  assign head_vals = rd_rec[VALS_W-1:0];
  assign mask_ext  = MAX_OUTPUTS'(head_mask);
  assign first_idx = next_set_bit(mask_ext, 6'd0);
  assign next_idx  = next_set_bit(mask_ext, idx_q + 6'd1);
  assign is_last   = (next_idx >= 6'(NUM_OUTPUTS));

  always_comb begin
    cur_val = '0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (32'(idx_q) == i) cur_val = head_vals[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_TS_MSB -: TS_W]            = head_ts;
    hdr_word[HDR_MASK_LSB +: NUM_OUTPUTS]   = head_mask;
  end

  assign val_word = 64'($signed(cur_val));

  // The head record stays in place until its last word is accepted; the
  // back-to-back decision counts a record pushed at that same edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: if (!empty) state_d = HDR;
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
        if (out_ready) begin
          state_d = VAL;
          idx_d   = first_idx;
        end
      end
      VAL: begin
        out_valid = 1'b1;
        out_data  = val_word;
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            pop     = 1'b1;
            state_d = ((fifo_level > LVL_W'(1)) || push_ok) ? HDR : IDLE;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d       = en ? ts_q + TS_W'(1) : ts_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push && !push_ok) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_monitor_verdict_serializer.sv
// Scoreboard bench for monitor_verdict_serializer: expected words queued on capture, compared on accept.
module tb_monitor_verdict_serializer;

  logic         clk = 1'b0;
  logic         rst, en, out_ready;
  logic [255:0] mon_data;
  logic [3:0]   mon_aktv;
  logic [63:0]  out_data;
  logic         out_valid, out_last, overflow;
  logic [15:0]  drop_count;
  logic [3:0]   fifo_level;

  always #5 clk = ~clk;

  monitor_verdict_serializer #(
    .NUM_OUTPUTS (4),
    .DATA_W      (64),
    .TS_W        (32),
    .FIFO_DEPTH  (8),
    .DROP_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mon_data   (mon_data),
    .mon_aktv   (mon_aktv),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  word_t       w;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_ts;
  int          m_level;
  int          m_drops;
  logic        ov, ol;
  logic [63:0] ow;

  function automatic logic [255:0] pack4(input logic signed [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Drives one cycle, samples outputs at the falling edge and updates the model.
  task automatic cycle(input logic e, input logic [3:0] ak, input logic [255:0] d, input logic rdy);
    logic popn;
    int   hi;
    en = e; mon_aktv = ak; mon_data = d; out_ready = rdy;
    @(negedge clk);
    ov = out_valid; ow = out_data; ol = out_last;
    if (!rst) begin
      exp_q.delete(); m_level = 0; m_ts = '0; m_drops = 0;
    end else begin
      popn = 1'b0;
      if (ov && rdy && exp_q.size() > 0) popn = exp_q[0].last;
      if (e && ak != 4'b0) begin
        if (m_level < 8 || popn) begin
          hi = 0;
          for (int i = 0; i < 4; i++) if (ak[i]) hi = i;
          exp_q.push_back('{data: {m_ts, 28'h0, ak}, last: 1'b0});
          for (int i = 0; i < 4; i++)
            if (ak[i]) exp_q.push_back('{data: d[i*64 +: 64], last: (i == hi)});
          m_level++;
        end else begin
          m_drops++;
        end
      end
      if (popn) m_level--;
      if (e) m_ts = m_ts + 32'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cycle(1'b0, 4'h0, '0, 1'b0);
    cycle(1'b0, 4'h0, '0, 1'b0);
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
  endtask

  task automatic test_single;
    int first = -1;
    int got   = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'h0, '0, 1'b1);
    cycle(1'b1, 4'b0101, pack4(7, -3, 9, 2), 1'b1);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 4'h0, '0, 1'b1);
      if (ov && first < 0) first = c;
      if (ov) begin
        if (got == 0) begin
          checks++;
          if (ow !== 64'h0000_0005_0000_0005) begin errors++; $display("FAIL single_header: got %h want %h", ow, 64'h0000_0005_0000_0005); end
        end
        got++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL single_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
    end
    checks++; if (first != 1) begin errors++; $display("FAIL single_latency: got %0d want 1", first); end
    checks++; if (got != 3) begin errors++; $display("FAIL single_count: got %0d want 3", got); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_backpressure;
    logic        r, prev_stall, prev_l;
    logic [63:0] prev_w;
    int          got = 0;
    prev_stall = 1'b0; prev_w = '0; prev_l = 1'b0;
    cycle(1'b1, 4'b1111, pack4(-1, 100, -200000, 64'sh7fff_ffff_ffff_fff0), 1'b1);
    for (int c = 0; c < 12; c++) begin
      r = !(c == 2 || c == 3);
      cycle(1'b1, 4'h0, '0, r);
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || ow !== prev_w || ol !== prev_l) begin
          errors++; $display("FAIL bp_stable: got %b/%h/%b want 1/%h/%b", ov, ow, ol, prev_w, prev_l);
        end
      end
      prev_stall = ov && !r; prev_w = ow; prev_l = ol;
      if (ov && r) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL bp_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL bp_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int lastc = -1;
    int got   = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 4) cycle(1'b1, 4'b0001, pack4(c + 1, 0, 0, 0), 1'b1);
      else       cycle(1'b1, 4'h0, '0, 1'b1);
      if (ov) begin
        if (first < 0) first = c;
        lastc = c;
        got++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL b2b_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    checks++; if (lastc - first + 1 != 8) begin errors++; $display("FAIL b2b_gapless: got span %0d want 8", lastc - first + 1); end
  endtask

  task automatic test_overflow;
    int pk = 0;
    for (int c = 0; c < 10; c++) cycle(1'b1, 4'b0001, pack4(100 + c, 0, 0, 0), 1'b0);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    checks++; if (drop_count !== 16'(m_drops) || m_drops != 2) begin errors++; $display("FAIL ovf_drops: got %0d want 2", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int c = 0; c < 30; c++) begin
      cycle(1'b1, 4'h0, '0, 1'b1);
      if (ov) begin
        if (ol) pk++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ovf_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL ovf_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
    end
    checks++; if (pk != 8) begin errors++; $display("FAIL ovf_packets: got %0d want 8", pk); end
  endtask

  task automatic test_full_pop;
    logic r;
    for (int c = 0; c < 40; c++) begin
      r = (c >= 8);
      if (c < 8)       cycle(1'b1, 4'b0001, pack4(200 + c, 0, 0, 0), r);
      else if (c == 9) cycle(1'b1, 4'b0010, pack4(0, -77, 0, 0), r);
      else             cycle(1'b1, 4'h0, '0, r);
      if (ov && r) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fullpop_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL fullpop_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
      if (c == 9) begin
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_level: got %0d want 8", fifo_level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL fullpop_drops: got %0d want 2", drop_count); end
      end
    end
    checks++; if (exp_q.size() != 0 || fifo_level !== 4'd0) begin errors++; $display("FAIL fullpop_drain: got %0d words/%0d level want 0/0", exp_q.size(), fifo_level); end
  endtask

  task automatic test_reset_en;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) cycle(1'b1, 4'b1111, pack4(11, 22, 33, 44), 1'b1);
      else        cycle(1'b1, 4'h0, '0, 1'b1);
      if (ov) begin
        checks++;
        w = exp_q.pop_front();
        if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL rst_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
      end
    end
    rst = 1'b0;
    cycle(1'b0, 4'h0, '0, 1'b0);
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 4'b1111, pack4(1, 2, 3, 4), 1'b1);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL en_gate_valid: got %b want 0", ov); end
    end
    cycle(1'b1, 4'b0001, pack4(-5, 0, 0, 0), 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 4'h0, '0, 1'b1);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL en_word: got %h want no word", ow); end
        else begin
          w = exp_q.pop_front();
          if (w.last == 1'b0 && w.data !== 64'h1) begin errors++; $display("FAIL en_model_ts: got %h want %h", w.data, 64'h1); end
          if (ow !== w.data || ol !== w.last) begin errors++; $display("FAIL en_word: got %h/%b want %h/%b", ow, ol, w.data, w.last); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL en_drain: got %0d words left want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; out_ready = 1'b0; mon_aktv = '0; mon_data = '0;
    m_ts = '0; m_level = 0; m_drops = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_en();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
